// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module : data_mem_responder
// Handshaked 64-bit data memory target with configurable wait states.
// Rev    : 1.0
// ============================================================================
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int         c_idx_w = $clog2(DEPTH);
  localparam logic [7:0] c_wait  = 8'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic        write_q, write_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_error_q, rsp_error_d;
  logic [63:0] rsp_rdata_q, rsp_rdata_d;

  logic [63:0]        mem [DEPTH];
  logic [c_idx_w-1:0] idx;
  logic               addr_err;
  logic               mem_we;

  assign idx      = addr_q[c_idx_w+2:3];
  // Any set bit above the word index means the byte address is past the array.
  assign addr_err = (addr_q[2:0] != 3'b000) || (|addr_q[63:c_idx_w+3]);

  assign req_ready = (state_q == S_IDLE) && !reset;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_error_d = rsp_error_q;
    rsp_rdata_d = rsp_rdata_q;
    mem_we      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          count_d = c_wait;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (count_q != 8'd0) begin
          count_d = count_q - 8'd1;
        end else begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 64'd0;
          if (addr_err) begin
            rsp_error_d = 1'b1;
          end else if (write_q) begin
            mem_we = 1'b1;
          end else begin
            rsp_rdata_d = mem[idx];
          end
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_error_d = 1'b0;
          rsp_rdata_d = 64'd0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= 8'd0;
      write_q     <= 1'b0;
      addr_q      <= 64'd0;
      wdata_q     <= 64'd0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= 64'd0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Array has no reset; an asserted reset forces IDLE, which drops mem_we.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= wdata_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_data_mem_responder
// Scoreboard bench for data_mem_responder (WAIT_CYCLES=2 main, 0 for b2b).
// Rev    : 1.0
// ============================================================================
module tb_data_mem_responder;

  localparam int DEPTH  = 256;
  localparam int WAIT   = 2;
  localparam int BUDGET = 300;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [63:0] req_addr = 64'd0, req_wdata = 64'd0;
  logic        req_ready, rsp_valid, rsp_error;
  logic [63:0] rsp_rdata;

  logic        req_valid_z = 1'b0, req_write_z = 1'b0, rsp_ready_z = 1'b0;
  logic [63:0] req_addr_z = 64'd0, req_wdata_z = 64'd0;
  logic        req_ready_z, rsp_valid_z, rsp_error_z;
  logic [63:0] rsp_rdata_z;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [63:0] ref_mem [DEPTH];
  logic [64:0] sb [$];
  logic [64:0] sb_z [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut_z (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_z), .req_ready(req_ready_z), .req_write(req_write_z),
    .req_addr(req_addr_z), .req_wdata(req_wdata_z),
    .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z),
    .rsp_rdata(rsp_rdata_z), .rsp_error(rsp_error_z)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour: returns {error, rdata} and applies legal stores.
  function automatic logic [64:0] model(input logic w, input logic [63:0] a, input logic [63:0] d);
    logic [7:0] i;
    i = a[10:3];
    if ((a[2:0] != 3'b000) || (a >= 64'(8 * DEPTH))) return {1'b1, 64'd0};
    if (w) begin
      ref_mem[i] = d;
      return {1'b0, 64'd0};
    end
    return {1'b0, ref_mem[i]};
  endfunction

  task automatic xact(input logic w, input logic [63:0] a, input logic [63:0] d,
                      input int stall, input bit poke);
    int n;
    logic [64:0] exp;
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < BUDGET) begin @(posedge clk); #1; n++; end
    if (!req_ready) begin
      check_eq("accept_timeout", {63'd0, req_ready}, 64'd1);
      req_valid = 1'b0;
      return;
    end
    sb.push_back(model(w, a, d));
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!rsp_valid && n < BUDGET);
    if (!rsp_valid) begin
      check_eq("rsp_timeout", {63'd0, rsp_valid}, 64'd1);
      void'(sb.pop_front());
      return;
    end
    check_eq("latency", 64'(n), 64'(WAIT + 1));
    exp = sb.pop_front();
    check_eq("rdata", rsp_rdata, exp[63:0]);
    check_eq("error", {63'd0, rsp_error}, {63'd0, exp[64]});
    if (poke) begin
      req_write = 1'b1; req_addr = 64'h20; req_wdata = 64'h5555; req_valid = 1'b1;
    end
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check_eq("stall_valid", {63'd0, rsp_valid}, 64'd1);
      check_eq("stall_rdata", rsp_rdata, exp[63:0]);
      check_eq("stall_error", {63'd0, rsp_error}, {63'd0, exp[64]});
      check_eq("stall_ready", {63'd0, req_ready}, 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check_eq("rsp_drop_valid", {63'd0, rsp_valid}, 64'd0);
    check_eq("rsp_drop_rdata", rsp_rdata, 64'd0);
    check_eq("idle_ready", {63'd0, req_ready}, 64'd1);
  endtask

  // Back-to-back store/load of 0x0 on the zero-wait instance, rsp_ready tied high.
  task automatic b2b_zero(input logic [63:0] v);
    int n, t_acc1, t_acc2;
    logic [64:0] exp;
    req_write_z = 1'b1; req_addr_z = 64'h0; req_wdata_z = v;
    req_valid_z = 1'b1; rsp_ready_z = 1'b1;
    n = 0;
    while (!req_ready_z && n < BUDGET) begin @(posedge clk); #1; n++; end
    check_eq("b2b_ready0", {63'd0, req_ready_z}, 64'd1);
    sb_z.push_back({1'b0, 64'd0});
    @(posedge clk); #1;
    t_acc1 = cyc;
    req_write_z = 1'b0;
    sb_z.push_back({1'b0, v});
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!rsp_valid_z && n < BUDGET);
      check_eq("b2b_latency", 64'(n), 64'd1);
      exp = sb_z.pop_front();
      check_eq("b2b_rdata", rsp_rdata_z, exp[63:0]);
      check_eq("b2b_error", {63'd0, rsp_error_z}, {63'd0, exp[64]});
      if (k == 0) begin
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!req_ready_z && n < BUDGET);
        check_eq("b2b_ready1", {63'd0, req_ready_z}, 64'd1);
        @(posedge clk); #1;
        t_acc2 = cyc;
        req_valid_z = 1'b0;
        check_eq("b2b_period", 64'(t_acc2 - t_acc1), 64'd3);
      end
    end
    @(posedge clk); #1;
    check_eq("b2b_drop", {63'd0, rsp_valid_z}, 64'd0);
    rsp_ready_z = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a;
    #12;
    check_eq("rst_req_ready", {63'd0, req_ready}, 64'd0);
    check_eq("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 64'd0);
    check_eq("rst_rsp_error", {63'd0, rsp_error}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_eq("post_rst_ready", {63'd0, req_ready}, 64'd1);

    for (int i = 0; i < DEPTH; i++) xact(1'b1, 64'(i * 8), 64'd0, 0, 1'b0);

    // Store aborted by reset while BUSY must leave the array untouched.
    req_write = 1'b1; req_addr = 64'h10; req_wdata = 64'hAA; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_eq("abort_req_ready", {63'd0, req_ready}, 64'd0);
    check_eq("abort_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_idle", {63'd0, req_ready}, 64'd1);
    xact(1'b0, 64'h10, 64'd0, 0, 1'b0);

    xact(1'b1, 64'h18, 64'hDEADBEEF_01234567, 0, 1'b0);
    xact(1'b0, 64'h18, 64'd0, 0, 1'b0);

    xact(1'b0, 64'h1C, 64'd0, 0, 1'b0);
    xact(1'b0, 64'h800, 64'd0, 0, 1'b0);
    xact(1'b1, 64'h1C, 64'h1111, 0, 1'b0);
    xact(1'b1, 64'h800, 64'h2222, 0, 1'b0);
    xact(1'b0, 64'h18, 64'd0, 0, 1'b0);
    xact(1'b0, 64'h0, 64'd0, 0, 1'b0);

    xact(1'b0, 64'h18, 64'd0, 5, 1'b1);
    xact(1'b0, 64'h20, 64'd0, 0, 1'b0);

    b2b_zero(64'hCAFE_F00D_1234_5678);

    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 9))
        0: a = {53'd0, 8'($urandom_range(0, 255)), 3'($urandom_range(1, 7))};
        1: a = {$urandom, $urandom} | 64'h800;
        default: a = {53'd0, 8'($urandom_range(0, 31)), 3'b000};
      endcase
      xact(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, $urandom_range(0, 3), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
